// File: rtl/count_wrap_monitor_pkg.sv
// Shared types and default sizes for the count wrap monitor.
// Holds the monitor FSM state enum, the step classification enum and the
// default widths that the top level and the testbench build against.
package count_mon_pkg;

   localparam int CNT_W_DEF       = 4;
   localparam int WRAP_W_DEF      = 8;
   localparam int STALL_LIMIT_DEF = 16;

   typedef enum logic [1:0] {
      SYNC,
      TRACK,
      ALARM
   } mon_state_t;

   typedef enum logic [2:0] {
      STEP_INC,
      STEP_WRAP,
      STEP_RST,
      STEP_HOLD,
      STEP_JUMP
   } step_t;

endpackage

// File: rtl/count_wrap_monitor_if.sv
// Bundle between the monitor and whoever drives it.
// The master side feeds the counter sample, enable, threshold and ack;
// the slave side (the monitor) returns the pulse, count and flag outputs.
interface count_wrap_monitor_if #(
   parameter int CNT_W  = 4,
   parameter int WRAP_W = 8
);

   logic              en;
   logic [CNT_W-1:0]  count_in;
   logic [WRAP_W-1:0] wrap_thresh;
   logic              irq_ack;
   logic              wrap_pulse;
   logic [WRAP_W-1:0] wrap_count;
   logic              err_jump;
   logic              stall;
   logic              irq;

   modport master (
      output en, count_in, wrap_thresh, irq_ack,
      input  wrap_pulse, wrap_count, err_jump, stall, irq
   );

   modport slave (
      input  en, count_in, wrap_thresh, irq_ack,
      output wrap_pulse, wrap_count, err_jump, stall, irq
   );

endinterface

// File: rtl/count_wrap_monitor_wrap_accum.sv
// Saturating wrap accumulator with threshold compare.
// A clear and an increment in the same cycle leave the count at one, so a
// wrap that coincides with an acknowledge is never lost. The threshold hit
// is evaluated on the value about to be stored so the owner can react in the
// same cycle the count changes.
module wrap_accum #(
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              inc,
   input  logic [WRAP_W-1:0] thresh,
   output logic [WRAP_W-1:0] count,
   output logic              hit
);

   localparam logic [WRAP_W-1:0] COUNT_MAX = '1;

   logic [WRAP_W-1:0] count_next;

   // Clear takes priority, then a pending increment is applied on top,
   // saturating at all ones.
   always_comb begin
      count_next = clr ? '0 : count;
      if (inc && (count_next != COUNT_MAX)) begin
         count_next = count_next + 1'b1;
      end
   end

   assign hit = (thresh != '0) && (count_next >= thresh);

   // Accumulator register, cleared by the active-low asynchronous reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/count_wrap_monitor.sv
// Count wrap monitor: watches a free-running up counter, classifies each
// step (increment, wrap, upstream reset, hold, illegal jump), accumulates
// wraps and raises a level interrupt at a programmable threshold.
// Optional build macro STALL_DETECT_EN adds the held-count stall detector;
// without it the stall output is tied low and holds are harmless.
// Reset input 'reset' is asynchronous and active low.
module count_wrap_monitor
   import count_mon_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int WRAP_W      = WRAP_W_DEF,
   parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
   input logic                 clk,
   input logic                 reset,
   count_wrap_monitor_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if (STALL_LIMIT < 2) begin : g_limit_check
      $error("count_wrap_monitor: STALL_LIMIT must be at least 2");
   end

   mon_state_t        state;
   mon_state_t        state_next;
   logic [CNT_W-1:0]  prev;
   logic [CNT_W-1:0]  prev_next;
   step_t             step;
   logic              classify;
   logic              wrap_det;
   logic              jump_det;
   logic              wrap_pulse_q;
   logic              err_jump_q;
   logic              err_next;
   logic              irq_q;
   logic              irq_next;
   logic [WRAP_W-1:0] wrap_count;
   logic              thresh_hit;

   // A step is only judged once a previous sample has been captured.
   assign classify = bus.en && (state != SYNC);
   assign wrap_det = classify && (step == STEP_WRAP);
   assign jump_det = classify && (step == STEP_JUMP);

   // The acknowledge clears the sticky flag first, so a jump seen in the
   // same cycle still leaves it set.
   assign err_next = (err_jump_q && !bus.irq_ack) || jump_det;

   // Classify the current sample against the previous one; the wrap case is
   // tested first because max->0 also looks like a +1 modulo the width.
   always_comb begin
      step = STEP_JUMP;
      if ((prev == CNT_MAX) && (bus.count_in == '0)) begin
         step = STEP_WRAP;
      end else if (bus.count_in == prev + CNT_ONE) begin
         step = STEP_INC;
      end else if (bus.count_in == prev) begin
         step = STEP_HOLD;
      end else if (bus.count_in == '0) begin
         step = STEP_RST;
      end
   end

   wrap_accum #(
      .WRAP_W (WRAP_W)
   ) u_wrap_accum (
      .clk    (clk),
      .reset  (reset),
      .clr    (bus.irq_ack),
      .inc    (wrap_det),
      .thresh (bus.wrap_thresh),
      .count  (wrap_count),
      .hit    (thresh_hit)
   );

   // Next-state logic. Dropping enable always forces a resync; leaving SYNC
   // returns to ALARM if an interrupt is still outstanding so the ack rules
   // stay consistent across an enable gap.
   always_comb begin
      state_next = state;
      prev_next  = prev;
      irq_next   = irq_q && !bus.irq_ack;
      case (state)
         SYNC: begin
            if (bus.en) begin
               prev_next  = bus.count_in;
               state_next = irq_next ? ALARM : TRACK;
            end
         end
         TRACK: begin
            if (!bus.en) begin
               state_next = SYNC;
            end else begin
               prev_next = bus.count_in;
               if (thresh_hit) begin
                  state_next = ALARM;
                  irq_next   = 1'b1;
               end
            end
         end
         ALARM: begin
            if (!bus.en) begin
               state_next = SYNC;
            end else begin
               prev_next = bus.count_in;
               if (bus.irq_ack) begin
                  state_next = TRACK;
               end
            end
         end
         default: begin
            state_next = SYNC;
         end
      endcase
   end

   // State, previous sample and registered flag outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= SYNC;
         prev         <= '0;
         wrap_pulse_q <= 1'b0;
         err_jump_q   <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state        <= state_next;
         prev         <= prev_next;
         wrap_pulse_q <= wrap_det;
         err_jump_q   <= err_next;
         irq_q        <= irq_next;
      end
   end

`ifdef STALL_DETECT_EN
   localparam int                    STALL_CW  = $clog2(STALL_LIMIT + 1);
   localparam logic [STALL_CW-1:0]   STALL_MAX = STALL_CW'(STALL_LIMIT);

   logic [STALL_CW-1:0] stall_cnt;
   logic [STALL_CW-1:0] stall_cnt_next;
   logic                stall_q;
   logic                sync_load;

   assign sync_load = bus.en && (state == SYNC);

   // Count consecutive held samples, saturating at the limit; any other
   // step or a fresh resync starts the run over.
   always_comb begin
      stall_cnt_next = stall_cnt;
      if (sync_load) begin
         stall_cnt_next = '0;
      end else if (classify) begin
         if (step != STEP_HOLD) begin
            stall_cnt_next = '0;
         end else if (stall_cnt != STALL_MAX) begin
            stall_cnt_next = stall_cnt + 1'b1;
         end
      end
   end

   // Stall run counter and its registered limit flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         stall_q   <= 1'b0;
      end else begin
         stall_cnt <= stall_cnt_next;
         stall_q   <= (stall_cnt_next == STALL_MAX);
      end
   end

   assign bus.stall = stall_q;
`else
   assign bus.stall = 1'b0;
`endif

   assign bus.wrap_pulse = wrap_pulse_q;
   assign bus.wrap_count = wrap_count;
   assign bus.err_jump   = err_jump_q;
   assign bus.irq        = irq_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Testbench for count_wrap_monitor.
// Stimulus is driven on the falling edge; a reference model computes the
// outputs expected after the next rising edge and queues them. A separate
// monitor pops and compares shortly after every rising edge.
module tb_count_wrap_monitor;

   localparam int CNT_W       = 4;
   localparam int WRAP_W      = 8;
   localparam int STALL_LIMIT = 16;
   localparam int CNT_TOP     = (1 << CNT_W) - 1;
   localparam int WRAP_TOP    = (1 << WRAP_W) - 1;

   typedef struct packed {
      logic              wrap_pulse;
      logic [WRAP_W-1:0] wrap_count;
      logic              err_jump;
      logic              stall;
      logic              irq;
   } obs_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;
   int step_no      = 0;

   obs_t exp_q[$];
   int   tag_q[$];

   bit m_synced;
   int m_prev;
   int m_wraps;
   bit m_err;
   bit m_irq;
   int m_hold;

   count_wrap_monitor_if #(.CNT_W(CNT_W), .WRAP_W(WRAP_W)) bus ();

   count_wrap_monitor #(
      .CNT_W       (CNT_W),
      .WRAP_W      (WRAP_W),
      .STALL_LIMIT (STALL_LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input obs_t exp_v, input string tag);
      obs_t act;
      act.wrap_pulse = bus.wrap_pulse;
      act.wrap_count = bus.wrap_count;
      act.err_jump   = bus.err_jump;
      act.stall      = bus.stall;
      act.irq        = bus.irq;
      tests_run++;
      if (act !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL %s: got pulse=%0b count=%0d err=%0b stall=%0b irq=%0b, expected pulse=%0b count=%0d err=%0b stall=%0b irq=%0b",
                  tag, act.wrap_pulse, act.wrap_count, act.err_jump, act.stall, act.irq,
                  exp_v.wrap_pulse, exp_v.wrap_count, exp_v.err_jump, exp_v.stall, exp_v.irq);
      end
   endtask

   task automatic resetModel();
      m_synced = 1'b0;
      m_prev   = 0;
      m_wraps  = 0;
      m_err    = 1'b0;
      m_irq    = 1'b0;
      m_hold   = 0;
   endtask

   // Drive one sample and queue the outputs the monitor should show for it.
   task automatic applyStimulus(input bit e, input int c, input int th, input bit ack);
      obs_t exp_v;
      bit   pulse;
      int   diff;
      bit   is_wrap;
      bit   is_inc;
      bit   is_hold;
      bit   is_rst;
      @(negedge clk);
      bus.en          = e;
      bus.count_in    = CNT_W'(c);
      bus.wrap_thresh = WRAP_W'(th);
      bus.irq_ack     = ack;
      pulse = 1'b0;
      if (ack) begin
         m_wraps = 0;
         m_err   = 1'b0;
      end
      if (e && m_synced) begin
         diff    = (c - m_prev + CNT_TOP + 1) % (CNT_TOP + 1);
         is_wrap = (m_prev == CNT_TOP) && (c == 0);
         is_hold = (diff == 0);
         is_inc  = (diff == 1) && !is_wrap;
         is_rst  = (c == 0) && !is_wrap && !is_hold;
         if (is_wrap) begin
            pulse = 1'b1;
            if (m_wraps < WRAP_TOP) m_wraps++;
         end
         if (!(is_wrap || is_inc || is_hold || is_rst)) m_err = 1'b1;
         if (is_hold) begin
            if (m_hold < STALL_LIMIT) m_hold++;
         end else begin
            m_hold = 0;
         end
         if (m_irq) begin
            if (ack) m_irq = 1'b0;
         end else if ((th != 0) && (m_wraps >= th)) begin
            m_irq = 1'b1;
         end
         m_prev = c;
      end else begin
         if (ack) m_irq = 1'b0;
         if (e) begin
            m_synced = 1'b1;
            m_prev   = c;
            m_hold   = 0;
         end else begin
            m_synced = 1'b0;
         end
      end
      exp_v.wrap_pulse = pulse;
      exp_v.wrap_count = WRAP_W'(m_wraps);
      exp_v.err_jump   = m_err;
`ifdef STALL_DETECT_EN
      exp_v.stall      = (m_hold == STALL_LIMIT);
`else
      exp_v.stall      = 1'b0;
`endif
      exp_v.irq        = m_irq;
      step_no++;
      exp_q.push_back(exp_v);
      tag_q.push_back(step_no);
   endtask

   // Scoreboard monitor: compare the DUT against the oldest queued expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            checkOutput(exp_q.pop_front(), $sformatf("step%0d", tag_q.pop_front()));
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      obs_t zero_v;
      int   cnt;
      int   th;
      int   r;
      zero_v          = '0;
      bus.en          = 1'b0;
      bus.count_in    = '0;
      bus.wrap_thresh = '0;
      bus.irq_ack     = 1'b0;
      resetModel();

      #12;
      checkOutput(zero_v, "reset_state");
      @(negedge clk);
      reset = 1'b1;

      // Single ramp 0..15 then 0: exactly one wrap.
      for (int i = 0; i <= CNT_TOP; i++) applyStimulus(1'b1, i, 0, 1'b0);
      applyStimulus(1'b1, 0, 0, 1'b0);
      applyStimulus(1'b1, 1, 0, 1'b0);

      // Threshold 3: three wraps raise irq, two more keep counting.
      applyStimulus(1'b1, 2, 3, 1'b1);
      for (int w = 0; w < 5; w++) begin
         for (int i = 3; i <= CNT_TOP; i++) applyStimulus(1'b1, i, 3, 1'b0);
         for (int i = 0; i <= 2; i++) applyStimulus(1'b1, i, 3, 1'b0);
      end
      applyStimulus(1'b1, 3, 3, 1'b1);
      applyStimulus(1'b1, 4, 0, 1'b0);

      // Illegal jump 4,5,9 is sticky until acknowledged.
      applyStimulus(1'b1, 5, 0, 1'b0);
      applyStimulus(1'b1, 9, 0, 1'b0);
      applyStimulus(1'b1, 10, 0, 1'b0);
      applyStimulus(1'b1, 11, 0, 1'b0);
      applyStimulus(1'b1, 12, 0, 1'b1);

      // Upstream reset 6,7,0.
      applyStimulus(1'b1, 6, 0, 1'b0);
      applyStimulus(1'b1, 7, 0, 1'b0);
      applyStimulus(1'b1, 0, 0, 1'b0);
      applyStimulus(1'b1, 1, 0, 1'b0);

      // Hold 8 for the full stall limit, then move on.
      applyStimulus(1'b1, 8, 0, 1'b1);
      for (int i = 0; i < STALL_LIMIT; i++) applyStimulus(1'b1, 8, 0, 1'b0);
      applyStimulus(1'b1, 8, 0, 1'b0);
      applyStimulus(1'b1, 9, 0, 1'b0);

      // Enter ALARM with threshold 1, then ack on the cycle of a wrap.
      for (int i = 10; i <= CNT_TOP; i++) applyStimulus(1'b1, i, 1, 1'b0);
      applyStimulus(1'b1, 0, 1, 1'b0);
      for (int i = 1; i <= CNT_TOP; i++) applyStimulus(1'b1, i, 1, 1'b0);
      applyStimulus(1'b1, 0, 1, 1'b1);
      applyStimulus(1'b1, 1, 0, 1'b1);

      // Enable gap followed by resync at an unrelated value.
      applyStimulus(1'b0, 5, 0, 1'b0);
      applyStimulus(1'b1, 12, 0, 1'b0);
      applyStimulus(1'b1, 13, 0, 1'b0);

      // Randomised traffic, mostly ramping with holds, resets and jumps.
      cnt = 13;
      th  = 2;
      for (int n = 0; n < 2000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 78) cnt = (cnt + 1) % (CNT_TOP + 1);
         else if (r < 88) cnt = cnt;
         else if (r < 93) cnt = 0;
         else cnt = int'($urandom_range(0, CNT_TOP));
         if ($urandom_range(0, 49) == 0) th = int'($urandom_range(0, 4));
         applyStimulus($urandom_range(0, 15) != 0, cnt, th, $urandom_range(0, 19) == 0);
      end

      // Async reset in the middle of a ramp clears everything immediately.
      for (int i = 0; i <= CNT_TOP; i++) applyStimulus(1'b1, i, 1, 1'b0);
      applyStimulus(1'b1, 0, 1, 1'b0);
      applyStimulus(1'b1, 1, 1, 1'b0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput(zero_v, "async_reset");
      bus.en      = 1'b0;
      bus.irq_ack = 1'b0;
      resetModel();
      @(negedge clk);
      checkOutput(zero_v, "reset_held");
      reset = 1'b1;
      for (int i = 3; i <= CNT_TOP; i++) applyStimulus(1'b1, i, 0, 1'b0);
      applyStimulus(1'b1, 0, 0, 1'b0);
      applyStimulus(1'b1, 1, 0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
